// File: rtl/upg_loader.sv
// -----------------------------------------------------------------------------
// upg_loader
//
// UART program loader for the instruction RAM programmer port. Receives an
// 8N1 byte stream, takes a 16-bit little-endian word count, then assembles
// little-endian 32-bit words and emits one write strobe per word.
//
// Ports:
//   clk_i       programmer clock; all logic on posedge
//   rst_n_i     asynchronous active-low reset
//   enable_i    level; high arms the loader, low returns to idle and clears
//               done/error, counters and the write port
//   rx_i        UART serial input (asynchronous, idle high)
//   upg_wen_o   one-cycle write strobe
//   upg_adr_o   word address of the current write (held until next write)
//   upg_dat_o   write data (held until next write)
//   upg_done_o  sticky: transfer finished successfully
//   upg_err_o   sticky: framing error, oversize length or inter-byte timeout
//   busy_o      high from the first length byte until done or error
// -----------------------------------------------------------------------------
module upg_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned MAX_WORDS    = 16384,
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        rx_i,
    output logic        upg_wen_o,
    output logic [13:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [16:0]      MAX_LEN   = 17'(MAX_WORDS);

    // ---- stage p0/p1: two-flop synchroniser for the asynchronous rx line ----
    logic rx_p0, rx_p1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
        end
    end

    // ---- stage p2: byte receiver ----
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_sh;
    logic [7:0]       byte_p2;
    logic             vld_p2;
    logic             frm_err_p2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_p1) rx_next = RX_START;
            // Mid-start recheck rejects glitches shorter than half a bit.
            RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_p1 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_cnt == BIT_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_sh      <= 8'd0;
            byte_p2    <= 8'd0;
            vld_p2     <= 1'b0;
            frm_err_p2 <= 1'b0;
        end else begin
            vld_p2     <= 1'b0;
            frm_err_p2 <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= 3'd0;
                end
                RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_p1, rx_sh[7:1]};   // LSB arrives first
                        rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_p1) begin
                            vld_p2  <= 1'b1;
                            byte_p2 <= rx_sh;
                        end else begin
                            frm_err_p2 <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    // ---- stage p3: length/word assembly and programmer write port ----
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_DATA, S_DONE, S_ERR} state_t;

    state_t           state, state_next;
    logic [7:0]       len_lo;
    logic [15:0]      len_q;
    logic [15:0]      len_rx;
    logic [15:0]      wr_cnt;
    logic [1:0]       byte_idx;
    logic [23:0]      word_sh;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             wen_p3;
    logic [13:0]      adr_p3;
    logic [31:0]      dat_p3;

    assign len_rx  = {byte_p2, len_lo};
    assign tmo_hit = (tmo_cnt == TMO_LAST) && !vld_p2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frm_err_p2)  state_next = S_ERR;
                    else if (vld_p2) state_next = S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (frm_err_p2 || tmo_hit) begin
                        state_next = S_ERR;
                    end else if (vld_p2) begin
                        if (len_rx == 16'd0)                state_next = S_DONE;
                        else if ({1'b0, len_rx} > MAX_LEN)  state_next = S_ERR;
                        else                                state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    // Completion is judged during the final strobe so done
                    // appears on the following cycle.
                    if (wen_p3 && (wr_cnt + 16'd1 == len_q)) state_next = S_DONE;
                    else if (frm_err_p2 || tmo_hit)          state_next = S_ERR;
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        busy_o     = (state == S_LEN_HI) || (state == S_DATA);
        upg_done_o = (state == S_DONE);
        upg_err_o  = (state == S_ERR);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len_lo   <= 8'd0;
            len_q    <= 16'd0;
            wr_cnt   <= 16'd0;
            byte_idx <= 2'd0;
            word_sh  <= 24'd0;
            tmo_cnt  <= '0;
            wen_p3   <= 1'b0;
            adr_p3   <= 14'd0;
            dat_p3   <= 32'd0;
        end else if (!enable_i) begin
            len_lo   <= 8'd0;
            len_q    <= 16'd0;
            wr_cnt   <= 16'd0;
            byte_idx <= 2'd0;
            word_sh  <= 24'd0;
            tmo_cnt  <= '0;
            wen_p3   <= 1'b0;
            adr_p3   <= 14'd0;
            dat_p3   <= 32'd0;
        end else begin
            wen_p3 <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (vld_p2) len_lo <= byte_p2;
                end
                S_LEN_HI: begin
                    tmo_cnt <= vld_p2 ? '0 : tmo_cnt + 1'b1;
                    if (vld_p2) begin
                        len_q    <= len_rx;
                        wr_cnt   <= 16'd0;
                        byte_idx <= 2'd0;
                    end
                end
                S_DATA: begin
                    tmo_cnt <= vld_p2 ? '0 : tmo_cnt + 1'b1;
                    if (wen_p3) wr_cnt <= wr_cnt + 16'd1;
                    if (vld_p2) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_sh[7:0]   <= byte_p2;
                            2'd1: word_sh[15:8]  <= byte_p2;
                            2'd2: word_sh[23:16] <= byte_p2;
                            default: begin
                                wen_p3 <= 1'b1;
                                adr_p3 <= wr_cnt[13:0];
                                dat_p3 <= {byte_p2, word_sh};
                            end
                        endcase
                    end
                end
                default: tmo_cnt <= '0;
            endcase
        end
    end

    assign upg_wen_o = wen_p3;
    assign upg_adr_o = adr_p3;
    assign upg_dat_o = dat_p3;

endmodule

// File: tb/tb_upg_loader.sv
`timescale 1ns/1ps
module tb_upg_loader;

    localparam int CPB  = 4;
    localparam int TMO  = 200;
    localparam int MAXW = 16384;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        rx    = 1'b1;
    logic        wen, done, err, busy;
    logic [13:0] adr;
    logic [31:0] dat;

    upg_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .enable_i  (en),
        .rx_i      (rx),
        .upg_wen_o (wen),
        .upg_adr_o (adr),
        .upg_dat_o (dat),
        .upg_done_o(done),
        .upg_err_o (err),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed write log and timing markers.
    logic [13:0] wa[$];
    logic [31:0] wd[$];
    int   last_wen_cyc = -1;
    int   done_cyc     = -1;
    int   viol         = 0;
    logic busy_prev        = 1'b0;
    logic busy_before_done = 1'b0;

    always @(negedge clk) begin
        if (wen) begin
            wa.push_back(adr);
            wd.push_back(dat);
            last_wen_cyc = cyc;
        end
        if (!done) done_cyc = -1;
        else if (done_cyc < 0) begin
            done_cyc = cyc;
            busy_before_done = busy_prev;
        end
        if ((done && err) || (wen && !busy)) viol++;
        busy_prev = busy;
    end

    // Reference model: expected writes and final status from the byte stream.
    logic [7:0]  dq[$];
    logic [13:0] ea[$];
    logic [31:0] ed[$];
    logic        e_done, e_err;

    task automatic model(input int len, input int ngood, input bit fault);
        ea.delete();
        ed.delete();
        e_done = 1'b0;
        e_err  = 1'b0;
        if (len > MAXW) begin
            e_err = 1'b1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            if (4 * w + 3 >= ngood) break;
            ea.push_back(14'(w));
            ed.push_back({dq[4*w+3], dq[4*w+2], dq[4*w+1], dq[4*w]});
        end
        if (fault)                e_err  = 1'b1;
        else if (ngood >= 4*len)  e_done = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        clocks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clocks(CPB);
        end
        rx = stop_bit;
        clocks(CPB);
        rx = 1'b1;
    endtask

    // Length bytes then dq; the byte at bad_idx gets a low stop bit and ends the stream.
    task automatic send_stream(input logic [15:0] len, input int bad_idx);
        send_byte(len[7:0], 1'b1);
        send_byte(len[15:8], 1'b1);
        for (int i = 0; i < dq.size(); i++) begin
            if (i == bad_idx) begin
                send_byte(dq[i], 1'b0);
                break;
            end
            send_byte(dq[i], 1'b1);
        end
    endtask

    task automatic fill_rand(input int n);
        dq.delete();
        for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
    endtask

    task automatic wait_status(input string tag, input int budget);
        int n = 0;
        while (!(done || err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, 64'(done || err), 64'd1);
    endtask

    task automatic verify(input string tag, input int base);
        chk({tag, "_done"}, 64'(done), 64'(e_done));
        chk({tag, "_err"},  64'(err),  64'(e_err));
        chk({tag, "_nwr"},  64'(wa.size() - base), 64'(ea.size()));
        for (int i = 0; i < ea.size() && base + i < wa.size(); i++) begin
            chk({tag, "_adr"}, 64'(wa[base+i]), 64'(ea[i]));
            chk({tag, "_dat"}, 64'(wd[base+i]), 64'(ed[i]));
        end
    endtask

    task automatic rearm(input string tag);
        en = 1'b0;
        clocks(2);
        chk({tag, "_clr"}, 64'({wen, adr, dat, done, err, busy}), 64'd0);
        en = 1'b1;
        clocks(1);
    endtask

    initial begin
        int base;
        int len;

        clocks(2);
        chk("reset_state", 64'({wen, adr, dat, done, err, busy}), 64'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        clocks(3);

        // Basic two-word load
        dq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
        base = wa.size();
        send_stream(16'd2, -1);
        wait_status("basic", 100);
        clocks(2);
        model(2, 8, 1'b0);
        verify("basic", base);
        chk("basic_done_lat",  64'(done_cyc - last_wen_cyc), 64'd1);
        chk("basic_busy_fall", 64'({busy_before_done, busy}), 64'b10);

        // Zero length
        rearm("zero");
        dq.delete();
        base = wa.size();
        send_stream(16'd0, -1);
        wait_status("zero", 100);
        clocks(5);
        model(0, 0, 1'b0);
        verify("zero", base);

        // Oversize length, then exactly the maximum is accepted
        rearm("over");
        base = wa.size();
        send_stream(16'h4001, -1);
        wait_status("over", 100);
        clocks(5);
        model(16'h4001, 0, 1'b0);
        verify("over", base);
        rearm("maxlen");
        send_stream(16'h4000, -1);
        clocks(10);
        chk("maxlen_accept", 64'({busy, done, err}), 64'b100);

        // Framing error on byte 3 of word 0; later stream ignored while in error
        rearm("frm");
        fill_rand(8);
        base = wa.size();
        send_stream(16'd2, 2);
        wait_status("frm", 100);
        clocks(2);
        model(2, 2, 1'b1);
        verify("frm", base);
        clocks(40);
        fill_rand(4);
        send_stream(16'd1, -1);
        clocks(20);
        chk("frm_sticky", 64'({done, err, busy}), 64'b010);
        chk("frm_nowr",   64'(wa.size() - base), 64'd0);

        // Framing error in word 1: word 0 stays written
        rearm("frm1");
        fill_rand(8);
        base = wa.size();
        send_stream(16'd2, 6);
        wait_status("frm1", 100);
        clocks(2);
        model(2, 6, 1'b1);
        verify("frm1", base);

        // Timeout mid-word, then full reload
        rearm("tmo");
        dq = '{8'hAA, 8'hBB};
        base = wa.size();
        send_stream(16'd1, -1);
        clocks(150);
        chk("tmo_not_early", 64'(err), 64'd0);
        wait_status("tmo", 150);
        model(1, 2, 1'b1);
        verify("tmo", base);
        rearm("tmo_clear");
        fill_rand(12);
        base = wa.size();
        send_stream(16'd3, -1);
        wait_status("tmo_reload", 100);
        clocks(2);
        model(3, 12, 1'b0);
        verify("tmo_reload", base);

        // One-clock glitch must not produce a byte
        rearm("glitch");
        rx = 1'b0;
        clocks(1);
        rx = 1'b1;
        clocks(60);
        chk("glitch_idle", 64'({busy, done, err}), 64'd0);
        fill_rand(4);
        base = wa.size();
        send_stream(16'd1, -1);
        wait_status("glitch", 100);
        clocks(2);
        model(1, 4, 1'b0);
        verify("glitch", base);

        // Asynchronous reset mid-DATA, then a fresh stream starts at address 0
        rearm("rst");
        fill_rand(12);
        send_byte(8'd3, 1'b1);
        send_byte(8'd0, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(dq[i], 1'b1);
        clocks(3);
        chk("pre_rst", 64'({busy, adr}), 64'({1'b1, 14'd1}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({wen, adr, dat, done, err, busy}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clocks(2);
        fill_rand(8);
        base = wa.size();
        send_stream(16'd2, -1);
        wait_status("post_rst", 100);
        clocks(2);
        model(2, 8, 1'b0);
        verify("post_rst", base);

        // Randomized loads
        for (int k = 0; k < 3; k++) begin
            len = $urandom_range(1, 5);
            rearm("rnd");
            fill_rand(4 * len);
            base = wa.size();
            send_stream(16'(len), -1);
            wait_status("rnd", 100);
            clocks(2);
            model(len, 4 * len, 1'b0);
            verify("rnd", base);
        end

        chk("invariants", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
